// File: rtl/tinyriscv_wb_pkg.sv
// Shared definitions for the tinyriscv Wishbone loader: register map,
// field positions, error word and FSM state encoding.
package tinyriscv_wb_pkg;

  localparam logic [23:0] OFF_CTRL    = 24'h00_0000;
  localparam logic [23:0] OFF_STATUS  = 24'h00_0004;
  localparam logic [23:0] OFF_SCRATCH = 24'h00_0008;

  // Address bit that steers an access into the instruction-memory window
  localparam int MEM_WIN_BIT = 20;

  localparam int CTRL_HOLD_BIT = 0;
  localparam int STAT_TO_BIT   = 0;
  localparam int STAT_BUSY_BIT = 1;

  // Returned on a memory access that never completed
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MREQ  = 2'd1,
    ST_MRESP = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // Byte-lane merge of write data into an existing word
  function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tinyriscv_wb_regs.sv
// Control/status/scratch registers of the loader. Writes are applied on the
// clock edge that accepts the bus request; reads are a combinational decode
// that the top registers into the acknowledge cycle.
module tinyriscv_wb_regs
  import tinyriscv_wb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [23:0] off_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  input  logic        to_set_i,
  input  logic        busy_i,
  output logic [31:0] rdata_o,
  output logic        cpu_hold_o
);

  logic        hold_q;
  logic        to_q;
  logic [31:0] scratch_q;

  logic wr_ctrl;
  logic wr_status;
  logic wr_scratch;

  assign wr_ctrl    = wr_en_i && (off_i == OFF_CTRL);
  assign wr_status  = wr_en_i && (off_i == OFF_STATUS);
  assign wr_scratch = wr_en_i && (off_i == OFF_SCRATCH);

  // Register updates; a timeout event beats a simultaneous clear of the sticky bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q    <= 1'b1;
      to_q      <= 1'b0;
      scratch_q <= '0;
    end else begin
      if (wr_ctrl && sel_i[0]) hold_q <= wdata_i[CTRL_HOLD_BIT];
      if (wr_scratch) scratch_q <= apply_sel(scratch_q, wdata_i, sel_i);
      if (to_set_i) begin
        to_q <= 1'b1;
      end else if (wr_status && sel_i[0] && wdata_i[STAT_TO_BIT]) begin
        to_q <= 1'b0;
      end
    end
  end

  // Read decode; unmapped offsets read as zero
  always_comb begin
    rdata_o = '0;
    case (off_i)
      OFF_CTRL:    rdata_o[CTRL_HOLD_BIT] = hold_q;
      OFF_STATUS: begin
        rdata_o[STAT_TO_BIT]   = to_q;
        rdata_o[STAT_BUSY_BIT] = busy_i;
      end
      OFF_SCRATCH: rdata_o = scratch_q;
      default:     rdata_o = '0;
    endcase
  end

  assign cpu_hold_o = hold_q;

endmodule

// File: rtl/tinyriscv_wb_loader.sv
// Wishbone classic slave that lets the management core hold the tinyriscv
// core in reset and load its instruction memory through a req/gnt/rvalid port.
module tinyriscv_wb_loader
  import tinyriscv_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          MEM_AW    = 12,
  parameter int          TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              cpu_rst_o
);

  // Counter only has to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the one that fires the error completion.
  localparam int              CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  state_e            state_q;
  logic              ack_q;
  logic [31:0]       dat_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [3:0]        mem_be_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [CW-1:0]     cnt_q;
  logic              lost_q;

  logic        sel_hit;
  logic        mem_hit;
  logic        reg_hit;
  logic        reg_wr;
  logic        in_mem;
  logic        abort_evt;
  logic        done_evt;
  logic        to_evt;
  logic        lost_now;
  logic [31:0] reg_rdata;
  logic        cpu_hold;

  assign sel_hit  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign mem_hit  = sel_hit && wbs_adr_i[MEM_WIN_BIT];
  assign reg_hit  = sel_hit && !wbs_adr_i[MEM_WIN_BIT];
  assign reg_wr   = (state_q == ST_IDLE) && reg_hit && wbs_we_i;

  assign in_mem    = (state_q == ST_MREQ) || (state_q == ST_MRESP);
  assign abort_evt = (state_q == ST_MREQ) && !wbs_cyc_i;
  assign done_evt  = ((state_q == ST_MREQ) && mem_gnt_i) ||
                     ((state_q == ST_MRESP) && mem_rvalid_i);
  // Completion in the last allowed cycle still counts as a normal completion
  assign to_evt    = in_mem && !abort_evt && !done_evt && (cnt_q == TO_LAST);
  // Once the initiator walks away during the read phase, the result is discarded
  assign lost_now  = lost_q || !wbs_cyc_i;

  tinyriscv_wb_regs u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wr_en_i    (reg_wr),
    .off_i      (wbs_adr_i[23:0]),
    .wdata_i    (wbs_dat_i),
    .sel_i      (wbs_sel_i),
    .to_set_i   (to_evt),
    .busy_i     (in_mem),
    .rdata_o    (reg_rdata),
    .cpu_hold_o (cpu_hold)
  );

  // Bus/memory sequencing FSM with registered bus and memory-port outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      lost_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q  <= 1'b0;
          dat_q  <= '0;
          cnt_q  <= '0;
          lost_q <= 1'b0;
          if (mem_hit) begin
            state_q     <= ST_MREQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= wbs_we_i;
            mem_be_q    <= wbs_sel_i;
            mem_addr_q  <= wbs_adr_i[MEM_AW+1:2];
            mem_wdata_q <= wbs_dat_i;
          end else if (reg_hit) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            dat_q   <= wbs_we_i ? 32'h0 : reg_rdata;
          end
        end

        ST_MREQ: begin
          if (abort_evt) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              dat_q   <= '0;
            end else begin
              state_q <= ST_MRESP;
              cnt_q   <= cnt_q + CW'(1);
            end
          end else if (to_evt) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_ACK;
            ack_q     <= 1'b1;
            dat_q     <= ERR_WORD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_MRESP: begin
          if (mem_rvalid_i) begin
            if (lost_now) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              dat_q   <= mem_rdata_i;
            end
          end else if (to_evt) begin
            if (lost_now) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              dat_q   <= ERR_WORD;
            end
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            lost_q <= lost_now;
          end
        end

        ST_ACK: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_rst_o   = cpu_hold || wb_rst_i;

endmodule

// File: tb/tb_tinyriscv_wb_loader.sv
// Self-checking bench for tinyriscv_wb_loader: directed scenarios plus a
// randomized mix of register and memory-window accesses against a
// transaction-level model of the register map and instruction memory.
module tb_tinyriscv_wb_loader;

  localparam int          MEM_AW  = 12;
  localparam int          TIMEOUT = 255;
  localparam logic [31:0] ERR_W   = 32'hDEAD_BEEF;
  localparam logic [31:0] MEM_BASE = 32'h3010_0000;
  localparam logic [31:0] REG_BASE = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              mem_req_o, mem_we_o;
  logic [3:0]        mem_be_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              cpu_rst_o;

  int n_checks = 0;
  int n_errors = 0;

  // Register-map model
  bit          hold_m;
  bit          to_m;
  logic [31:0] scratch_m;
  // Instruction-memory contents, keyed by word address
  logic [31:0] mem_m [int];

  // Responder configuration and expected memory-port values
  int                gnt_dly = 0;
  int                rv_dly  = 0;
  logic              exp_we;
  logic [3:0]        exp_be;
  logic [MEM_AW-1:0] exp_addr;
  logic [31:0]       exp_wdata;

  tinyriscv_wb_loader #(
    .BASE_ADDR (32'h3000_0000),
    .MEM_AW    (MEM_AW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .cpu_rst_o    (cpu_rst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    hold_m    = 1'b1;
    to_m      = 1'b0;
    scratch_m = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [23:0] off);
    case (off)
      24'h0:   return {31'b0, hold_m};
      24'h4:   return {31'b0, to_m};
      24'h8:   return scratch_m;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [23:0] off, input logic [31:0] d,
                                      input logic [3:0] s);
    case (off)
      24'h0: if (s[0]) hold_m = d[0];
      24'h4: if (s[0] && d[0]) to_m = 1'b0;
      24'h8: for (int b = 0; b < 4; b++) if (s[b]) scratch_m[8*b +: 8] = d[8*b +: 8];
      default: ;
    endcase
  endfunction

  task automatic check_reset_outputs(input string where);
    chk({where, "_ack"},   {31'b0, wbs_ack_o}, 0);
    chk({where, "_dat"},   wbs_dat_o, 0);
    chk({where, "_req"},   {31'b0, mem_req_o}, 0);
    chk({where, "_we"},    {31'b0, mem_we_o}, 0);
    chk({where, "_be"},    {28'b0, mem_be_o}, 0);
    chk({where, "_addr"},  {20'b0, mem_addr_o}, 0);
    chk({where, "_wdata"}, mem_wdata_o, 0);
    chk({where, "_cpurst"}, {31'b0, cpu_rst_o}, 1);
  endtask

  // One Wishbone classic access; waits at most budget cycles for ack
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int budget,
                           output logic [31:0] rd, output int lat, output bit acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0; acked = 1'b0; rd = '0;
    while (!acked && lat < budget) begin
      @(negedge clk);
      lat++;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rd    = wbs_dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", {31'b0, wbs_ack_o}, 0);
    chk("dat_zero_without_ack", wbs_dat_o, 0);
  endtask

  task automatic reg_op(input logic w, input logic [23:0] off, input logic [31:0] d,
                        input logic [3:0] s);
    logic [31:0] rd, expd;
    int          lat;
    bit          acked;
    expd = model_read(off);
    wb_access(w, REG_BASE | {8'h0, off}, d, s, 20, rd, lat, acked);
    if (w) model_write(off, d, s);
    chk($sformatf("reg_ack_%0h", off), {31'b0, acked}, 1);
    chk($sformatf("reg_lat_%0h", off), lat, 1);
    if (!w) chk($sformatf("reg_rd_%0h", off), rd, expd);
    chk("cpu_rst_vs_hold", {31'b0, cpu_rst_o}, {31'b0, hold_m});
  endtask

  task automatic mem_op(input logic w, input int word, input logic [31:0] d,
                        input logic [3:0] s, input int gd, input int rvd);
    logic [31:0] rd, expd;
    int          lat, explat, need;
    bit          acked, timed_out;
    gnt_dly = gd; rv_dly = rvd;
    exp_we = w; exp_be = s; exp_addr = word[MEM_AW-1:0]; exp_wdata = d;
    expd = 32'h0;
    if (!w) begin
      if (!mem_m.exists(word)) mem_m[word] = $urandom;
      expd = mem_m[word];
    end
    need      = w ? gd + 1 : gd + 2 + rvd;
    timed_out = (need > TIMEOUT);
    explat    = timed_out ? TIMEOUT + 1 : (w ? 2 + gd : 3 + gd + rvd);
    if (timed_out) begin
      expd = ERR_W;
      to_m = 1'b1;
    end
    wb_access(w, MEM_BASE | (32'(word) << 2), d, s, TIMEOUT + 50, rd, lat, acked);
    chk("mem_ack", {31'b0, acked}, 1);
    chk("mem_latency", lat, explat);
    if (!w || timed_out) chk("mem_rdata", rd, expd);
  endtask

  // Memory-side responder: grants after gnt_dly cycles of request, returns
  // read data rv_dly cycles after the grant, and checks the port contents.
  initial begin : responder
    int                g_cnt = 0;
    int                rv_cnt = 0;
    bit                rv_wait = 1'b0;
    bit                drop_chk = 1'b0;
    logic [MEM_AW-1:0] rv_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (drop_chk) begin
        if (!rst) chk("req_drop_after_gnt", {31'b0, mem_req_o}, 0);
        drop_chk = 1'b0;
      end
      if (rst) begin
        rv_wait = 1'b0;
        g_cnt   = 0;
      end else if (rv_wait) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_m.exists(int'(rv_addr)) ? mem_m[int'(rv_addr)] : 32'hxxxx_xxxx;
          rv_wait    = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (mem_req_o) begin
        if (g_cnt >= gnt_dly) begin
          mem_gnt  = 1'b1;
          g_cnt    = 0;
          drop_chk = 1'b1;
          chk("mem_addr", {20'b0, mem_addr_o}, {20'b0, exp_addr});
          chk("mem_be",   {28'b0, mem_be_o},   {28'b0, exp_be});
          chk("mem_we",   {31'b0, mem_we_o},   {31'b0, exp_we});
          if (mem_we_o) begin
            chk("mem_wdata", mem_wdata_o, exp_wdata);
            if (!mem_m.exists(int'(mem_addr_o))) mem_m[int'(mem_addr_o)] = '0;
            for (int b = 0; b < 4; b++)
              if (mem_be_o[b]) mem_m[int'(mem_addr_o)][8*b +: 8] = mem_wdata_o[8*b +: 8];
          end else begin
            rv_wait = 1'b1;
            rv_cnt  = rv_dly;
            rv_addr = mem_addr_o;
          end
        end else begin
          g_cnt++;
        end
      end else begin
        g_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rd;
    int          lat;
    bit          acked;
    logic [23:0] offs [6];
    offs[0] = 24'h0; offs[1] = 24'h4; offs[2] = 24'h8;
    offs[3] = 24'hC; offs[4] = 24'h10; offs[5] = 24'h40;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Release sequence: CTRL reads 1, clearing it releases the core
    reg_op(1'b0, 24'h0, 32'h0, 4'hF);
    chk("cpu_rst_after_reset", {31'b0, cpu_rst_o}, 1);
    reg_op(1'b1, 24'h0, 32'h0, 4'hF);
    chk("cpu_rst_released", {31'b0, cpu_rst_o}, 0);

    // Partial write into memory, grant after 3 cycles
    mem_op(1'b1, 2, 32'h1234_5678, 4'b0011, 3, 0);
    // Read with immediate grant, data 5 cycles later
    mem_m[1] = 32'hCAFE_F00D;
    mem_op(1'b0, 1, 32'h0, 4'hF, 0, 4);

    // Byte-lane scratch write and unmapped offset
    reg_op(1'b1, 24'h8, 32'hFFFF_FFFF, 4'b1000);
    reg_op(1'b0, 24'h8, 32'h0, 4'hF);
    reg_op(1'b0, 24'hC, 32'h0, 4'hF);

    // No grant: error completion, sticky bit, W1C (sel without byte 0 is ignored)
    mem_op(1'b0, 9, 32'h0, 4'hF, 100000, 0);
    reg_op(1'b0, 24'h4, 32'h0, 4'hF);
    reg_op(1'b1, 24'h4, 32'h1, 4'b1110);
    reg_op(1'b0, 24'h4, 32'h0, 4'hF);
    reg_op(1'b1, 24'h4, 32'h1, 4'hF);
    reg_op(1'b0, 24'h4, 32'h0, 4'hF);

    // Initiator gives up while waiting for grant
    gnt_dly = 100000;
    wb_access(1'b0, MEM_BASE | 32'h14, 32'h0, 4'hF, 3, rd, lat, acked);
    chk("abort_no_ack", {31'b0, acked}, 0);
    chk("abort_req_dropped", {31'b0, mem_req_o}, 0);
    repeat (3) @(negedge clk);
    chk("abort_still_no_ack", {31'b0, wbs_ack_o}, 0);

    // Foreign address is ignored
    wb_access(1'b0, 32'h2000_0000, 32'h0, 4'hF, 20, rd, lat, acked);
    chk("foreign_no_ack", {31'b0, acked}, 0);
    chk("foreign_no_req", {31'b0, mem_req_o}, 0);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        reg_op(1'($urandom_range(0, 1)), offs[$urandom_range(0, 5)], $urandom,
               4'($urandom_range(0, 15)));
      end else begin
        mem_op(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
               4'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom_range(0, 6));
      end
    end

    // Reset while waiting for read data
    gnt_dly = 0; rv_dly = 100000;
    exp_we = 1'b0; exp_be = 4'hF; exp_addr = 12'd7; exp_wdata = 32'h0;
    if (!mem_m.exists(7)) mem_m[7] = 32'h0BAD_CAFE;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = MEM_BASE | 32'h1C; sel = 4'hF;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_reset_no_ack", {31'b0, wbs_ack_o}, 0);
    chk("post_reset_cpu_held", {31'b0, cpu_rst_o}, 1);
    reg_op(1'b0, 24'h8, 32'h0, 4'hF);
    reg_op(1'b0, 24'h0, 32'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tinyriscv_wb_loader.md
TINYRISCV_WB_LOADER -- requirements
Module: tinyriscv_wb_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone decode base; only bits [31:24] compared.
REQ-002 SHALL have parameter MEM_AW, default 12, instruction-memory word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles waiting on memory before error completion.
REQ-004 SHALL use one clock and a synchronous, active-high reset: wb_clk_i is the sole clock and wb_rst_i is the synchronous active-high reset.
REQ-005 SHALL have ports:
  wb_clk_i  in  1  clock
  wb_rst_i  in  1  synchronous active-high reset
  wbs_cyc_i  in  1  bus cycle
  wbs_stb_i  in  1  strobe
  wbs_we_i  in  1  write enable
  wbs_sel_i  in  4  byte selects
  wbs_adr_i  in  32  byte address
  wbs_dat_i  in  32  write data
  wbs_ack_o  out  1  single-cycle acknowledge
  wbs_dat_o  out  32  read data
  mem_req_o  out  1  memory request, held until grant
  mem_we_o  out  1  memory write
  mem_be_o  out  4  memory byte enables
  mem_addr_o  out  MEM_AW  memory word address
  mem_wdata_o  out  32  memory write data
  mem_gnt_i  in  1  request accepted
  mem_rvalid_i  in  1  read data valid
  mem_rdata_i  in  32  read data
  cpu_rst_o  out  1  holds tinyriscv core in reset

Function
REQ-006 SHALL be a Wishbone classic slave (responder) for the management-core initiator; a request is cyc&stb with wbs_adr_i[31:24]==BASE_ADDR[31:24]; other addresses are ignored, never acked.
REQ-007 SHALL map offsets (wbs_adr_i[23:0]): 0x00 CTRL, bit0 = cpu_hold, R/W; 0x04 STATUS, bit0 = timeout sticky, bit1 = busy, write-1-to-clear bit0; 0x08 SCRATCH, 32-bit R/W; wbs_adr_i[20]==1 selects memory window with mem_addr_o = wbs_adr_i[MEM_AW+1:2].
REQ-008 SHALL ack unmapped register offsets with wbs_dat_o = 0 and no side effects.
REQ-009 SHALL apply wbs_sel_i per byte to SCRATCH and CTRL writes; STATUS clear uses byte 0 only.
REQ-010 SHALL implement FSM IDLE, MREQ, MRESP, ACK.
REQ-011 IDLE: register request sampled at edge k -> ACK; wbs_ack_o high for exactly the cycle after edge k, read data valid in that same cycle.
REQ-012 IDLE: memory request -> MREQ; mem_req_o, mem_we_o, mem_be_o=wbs_sel_i, mem_addr_o, mem_wdata_o registered and stable until grant.
REQ-013 MREQ: mem_gnt_i high -> writes go to ACK, reads go to MRESP; mem_req_o deasserts the cycle after grant.
REQ-014 MRESP: mem_rvalid_i high -> capture mem_rdata_i, go to ACK.
REQ-015 ACK: wbs_ack_o high one cycle, then IDLE; no new request is accepted in the ACK cycle.
REQ-016 SHALL count cycles in MREQ+MRESP; reaching TIMEOUT SHALL force ACK with wbs_dat_o = 32'hDEAD_BEEF, set STATUS bit0, drop mem_req_o.
REQ-017 If wbs_cyc_i drops in MREQ, SHALL drop mem_req_o and return to IDLE with no ack; if it drops in MRESP, SHALL wait for rvalid or timeout, then return to IDLE with no ack.
REQ-018 STATUS bit1 SHALL be 1 whenever state is MREQ or MRESP.
REQ-019 A timeout set and a W1C clear in the same cycle: the set SHALL win.
REQ-020 cpu_rst_o SHALL equal CTRL.cpu_hold OR wb_rst_i.
REQ-021 wbs_dat_o SHALL be 0 whenever wbs_ack_o is low.

Reset
REQ-022 On wb_rst_i, including mid-transaction: state IDLE, wbs_ack_o=0, wbs_dat_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, CTRL.cpu_hold=1, STATUS=0, SCRATCH=0, timeout counter=0; an outstanding request SHALL be abandoned with no ack.

Structure
REQ-023 The register offsets, field bit positions, the DEAD_BEEF error word and the FSM state enum SHALL live in shared package tinyriscv_wb_pkg.
REQ-024 Register file (CTRL/STATUS/SCRATCH) SHALL be sub-module tinyriscv_wb_regs; FSM and memory port stay in the top.

Verification
REQ-025 After reset: read 0x3000_0000 -> ack one cycle after request, dat=1, cpu_rst_o=1; write 0 -> cpu_rst_o=0.
REQ-026 Write 0x3010_0008 data 0x1234_5678, sel=4'b0011 -> mem_addr_o=2, mem_be_o=4'b0011, grant after 3 cycles -> ack one cycle after grant.
REQ-027 Read 0x3010_0004, gnt immediate, rvalid 5 cycles later with 0xCAFE_F00D -> ack with dat=0xCAFE_F00D.
REQ-028 Memory read, no gnt -> ack after TIMEOUT=255 cycles with 0xDEAD_BEEF, STATUS=1; write 1 to 0x3000_0004 -> STATUS=0.
REQ-029 Drop cyc in MREQ -> mem_req_o=0 next cycle, no ack; access to 0x2000_0000 -> no ack; reset asserted during MRESP -> all outputs to reset values.
REQ-030 SCRATCH write 0xFFFF_FFFF with sel=4'b1000 -> read back 0xFF00_0000; read offset 0x0C -> ack, dat=0.
